fine_time_pulse_gen: RTL and testbench
======================================

Name: fine_time_pulse_gen

Overview:
- Test-pulse transmitter for the 32-slice fine-time discriminator channel.
- Per 50 MHz clock, emits a 32-bit slice pattern word, bit k = slice k, slice 0 earliest. An external serializer drives the pattern onto the detector input line.
- Programmable start slice, width, repetition period and burst count, all set over the local bus.
- Also emits the expected one-hot leading-edge word, so the bench and the trigger can check the receiver's decode against it.

Parameters:
- Ch, 6'd0: register block base; registers sit at Address {Ch,2'b00}..{Ch,2'b11}.
- DefPeriod, 16'd50: PERIOD reset value, in clocks.

Ports:
- clk  in  1  50 MHz system clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- DataIn  in  32  local bus write data.
- Address  in  8  local bus address.
- Read  in  1  local bus read strobe.
- Write  in  1  local bus write strobe, one clk wide.
- DataOut  out  32  local bus read data; 0 unless Read is high and Address hits this block (bus is wired-OR).
- Pattern  out  32  registered slice pattern word.
- Expected  out  32  registered one-hot of the leading-edge slice; nonzero only while Marker is high.
- Marker  out  1  one-clock flag on the first word of each pulse.
- Busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst low, asynchronous): Pattern=0, Expected=0, Marker=0, Busy=0, state IDLE, SHAPE=0x00000100, PERIOD=DefPeriod, BURST=1, SENT=0.
- Registers are written on the posedge where Write is high and Address matches.
- Register map:
  - 00 CTRL: bit0 GO and bit1 ABORT, both self-clearing. Read returns {Busy,31'b0}.
  - 01 SHAPE: START[4:0], WIDTH[13:8]. Read returns the stored value.
  - 10 PERIOD[15:0].
  - 11 BURST[15:0], where 0 means continuous. Read returns {SENT[15:0],BURST[15:0]}.
- Read data is combinational from Address and Read.
- Clamping, applied at each pulse start:
  - WIDTH 0 is treated as 1; WIDTH>32 is treated as 32.
  - PERIOD<2 is treated as 2.
- States: IDLE, FIRE, SPILL, WAIT.
- IDLE:
  - GO write at edge E0 → FIRE at E0.
  - BURST is latched into the remaining-count register and SENT is cleared at E0.
  - Pattern=0.
- FIRE (one clock):
  - SHAPE and PERIOD are snapshotted at its entry; mid-pulse writes take effect at the next pulse.
  - At the next edge, load Pattern bits [START .. min(START+W,32)-1], Expected=1<<START, Marker=1, SENT+=1.
  - Period counter loads PERIOD-1.
  - Go to SPILL if START+W>32, else WAIT.
- SPILL (one clock): at the next edge, Pattern bits [0 .. START+W-33], Expected=0, Marker=0 → WAIT.
- WAIT:
  - Pattern=0; period counter decrements each clock.
  - When it reaches 0: if the burst is exhausted (remaining count hits 0, non-continuous) → IDLE; else → FIRE.
  - Leading edges of successive pulses are exactly PERIOD clocks apart.
- Latency: the first nonzero Pattern word appears at edge E1, one clock after the GO write edge E0.
- Priorities and corner cases:
  - ABORT: state goes to IDLE and Pattern/Expected/Marker go to 0 at the write edge. ABORT wins over a simultaneous GO.
  - GO while Busy is ignored.
  - BURST written mid-burst does not alter the running burst.
  - SENT wraps at 0xFFFF.
  - A continuous burst runs until ABORT or reset.
  - rst low mid-pulse clears everything immediately, including a partially emitted SPILL word.
- Width rules: START+W is computed 7-bit, with no wrap into the same word.

Test Plan:
- Reset defaults → read CTRL=0x00000000, SHAPE=0x00000100, BURST readback=0x00000001; Pattern=0.
- SHAPE START=4 W=4, BURST=1, GO → one clock later Pattern=0x000000F0, Expected=0x00000010, Marker=1; then Pattern=0, Busy drops after PERIOD clocks, SENT=1.
- START=30 W=5 → Pattern=0xC0000000, then next word 0x00000007; Expected=0x40000000 only on the first word.
- PERIOD=3 BURST=4 START=0 W=1 → Marker high at clocks 1,4,7,10 after GO; SENT=4; GO during the burst leaves SENT=4.
- BURST=0 continuous, then ABORT+GO in one write after 5 pulses → IDLE at that edge, Pattern=0, Busy=0.
- WIDTH=0, PERIOD=0 → treated as W=1, PERIOD=2; rst pulsed low mid-WAIT → all outputs 0 asynchronously.

Source files
------------

// File: rtl/fine_time_pulse_gen.sv
// fine_time_pulse_gen
//   Test-pulse transmitter for the 32-slice fine-time discriminator channel.
//   Each clock it emits one 32-bit slice pattern word (bit k = slice k, slice 0
//   earliest). A pulse starts at slice START and is WIDTH slices long. If it
//   runs past slice 31, the remainder spills into the low bits of the next word.
//   Pulses repeat every PERIOD clocks, for BURST pulses (0 = until ABORT).
//
// Ports
//   clk       50 MHz system clock, all logic on posedge
//   rst       asynchronous active-low reset
//   DataIn    local bus write data
//   Address   local bus address; this block decodes {Ch, 2'bxx}
//   Read      local bus read strobe
//   Write     local bus write strobe (one clk wide)
//   DataOut   local bus read data, 0 unless Read high and Address hits (wired-OR bus)
//   Pattern   registered slice pattern word
//   Expected  registered one-hot of the leading-edge slice (only with Marker)
//   Marker    one-clock flag on the first word of each pulse
//   Busy      high whenever the sequencer is not idle
//
// Register map (word offset = Address[1:0])
//   0 CTRL   W: bit0 GO, bit1 ABORT (self-clearing)    R: {Busy, 31'b0}
//   1 SHAPE  START[4:0], WIDTH[13:8]                  R: stored value
//   2 PERIOD [15:0] clocks between leading edges
//   3 BURST  [15:0] pulse count, 0 = continuous       R: {SENT, BURST}
//
// Bus protocol: a write is a single-cycle strobe. Write high with a matching
// Address commits DataIn on that posedge; there is no back-pressure, so every
// strobe is accepted. Reads are combinational and side-effect free.
module fine_time_pulse_gen #(
  parameter logic [5:0]  Ch        = 6'd0,
  parameter logic [15:0] DefPeriod = 16'd50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] DataIn,
  input  logic [7:0]  Address,
  input  logic        Read,
  input  logic        Write,
  output logic [31:0] DataOut,
  output logic [31:0] Pattern,
  output logic [31:0] Expected,
  output logic        Marker,
  output logic        Busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FIRE  = 2'd1,
    S_SPILL = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] shape_q, shape_d;
  logic [15:0] period_q, period_d;
  logic [15:0] burst_q, burst_d;
  logic [15:0] sent_q, sent_d;
  logic [15:0] remain_q, remain_d;
  logic        cont_q, cont_d;
  logic [15:0] cnt_q, cnt_d;
  logic [4:0]  snap_start_q, snap_start_d;
  logic [5:0]  snap_width_q, snap_width_d;
  logic [15:0] snap_period_q, snap_period_d;
  logic [31:0] pattern_q, pattern_d;
  logic [31:0] expected_q, expected_d;
  logic        marker_q, marker_d;

  logic        hit;
  logic        wr_hit;
  logic        go;
  logic        abort;
  logic [5:0]  width_clamp;
  logic [15:0] period_clamp;
  logic [63:0] ones_w;
  logic [63:0] mask;
  logic [6:0]  end_sum;
  logic        period_end;

  assign hit    = (Address[7:2] == Ch);
  assign wr_hit = Write && hit;
  assign abort  = wr_hit && (Address[1:0] == 2'b00) && DataIn[1];
  // ABORT beats a GO carried in the same write.
  assign go     = wr_hit && (Address[1:0] == 2'b00) && DataIn[0] && !abort;

  // Clamped view of the live registers, captured whenever a pulse is started.
  assign width_clamp  = (shape_q[13:8] == 6'd0)  ? 6'd1 :
                        (shape_q[13:8] > 6'd32)  ? 6'd32 : shape_q[13:8];
  assign period_clamp = (period_q < 16'd2) ? 16'd2 : period_q;

  // The pulse occupies bits [start, start+width) of a 64-bit two-word window:
  // the low half is the FIRE word, the high half the SPILL word.
  assign ones_w  = (64'd1 << snap_width_q) - 64'd1;
  assign mask    = ones_w << snap_start_q;
  assign end_sum = {2'b00, snap_start_q} + {1'b0, snap_width_q};

  // The period counter is loaded with PERIOD-1 on the leading-edge word and
  // counts in both SPILL and WAIT, so leading edges are exactly PERIOD apart
  // even when PERIOD is 2 and the pulse spills.
  assign period_end = (cnt_q <= 16'd1);

  always_comb begin
    state_d       = state_q;
    shape_d       = shape_q;
    period_d      = period_q;
    burst_d       = burst_q;
    sent_d        = sent_q;
    remain_d      = remain_q;
    cont_d        = cont_q;
    cnt_d         = cnt_q;
    snap_start_d  = snap_start_q;
    snap_width_d  = snap_width_q;
    snap_period_d = snap_period_q;
    pattern_d     = 32'd0;
    expected_d    = 32'd0;
    marker_d      = 1'b0;

    if (wr_hit) begin
      case (Address[1:0])
        2'b01:   shape_d  = DataIn;
        2'b10:   period_d = DataIn[15:0];
        2'b11:   burst_d  = DataIn[15:0];
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d       = S_FIRE;
          remain_d      = burst_q;
          cont_d        = (burst_q == 16'd0);
          sent_d        = 16'd0;
          snap_start_d  = shape_q[4:0];
          snap_width_d  = width_clamp;
          snap_period_d = period_clamp;
        end
      end
      S_FIRE: begin
        pattern_d  = mask[31:0];
        expected_d = 32'd1 << snap_start_q;
        marker_d   = 1'b1;
        sent_d     = sent_q + 16'd1;
        cnt_d      = snap_period_q - 16'd1;
        if (!cont_q) remain_d = remain_q - 16'd1;
        state_d    = (end_sum > 7'd32) ? S_SPILL : S_WAIT;
      end
      S_SPILL, S_WAIT: begin
        if (state_q == S_SPILL) pattern_d = mask[63:32];
        if (period_end) begin
          cnt_d = 16'd0;
          if (!cont_q && (remain_q == 16'd0)) begin
            state_d = S_IDLE;
          end else begin
            state_d       = S_FIRE;
            snap_start_d  = shape_q[4:0];
            snap_width_d  = width_clamp;
            snap_period_d = period_clamp;
          end
        end else begin
          cnt_d   = cnt_q - 16'd1;
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // ABORT drops everything on its write edge; a pulse that would have been
    // emitted on this edge is not emitted and not counted.
    if (abort) begin
      state_d    = S_IDLE;
      sent_d     = sent_q;
      pattern_d  = 32'd0;
      expected_d = 32'd0;
      marker_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      shape_q       <= 32'h0000_0100;
      period_q      <= DefPeriod;
      burst_q       <= 16'd1;
      sent_q        <= 16'd0;
      remain_q      <= 16'd0;
      cont_q        <= 1'b0;
      cnt_q         <= 16'd0;
      snap_start_q  <= 5'd0;
      snap_width_q  <= 6'd1;
      snap_period_q <= 16'd2;
      pattern_q     <= 32'd0;
      expected_q    <= 32'd0;
      marker_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      shape_q       <= shape_d;
      period_q      <= period_d;
      burst_q       <= burst_d;
      sent_q        <= sent_d;
      remain_q      <= remain_d;
      cont_q        <= cont_d;
      cnt_q         <= cnt_d;
      snap_start_q  <= snap_start_d;
      snap_width_q  <= snap_width_d;
      snap_period_q <= snap_period_d;
      pattern_q     <= pattern_d;
      expected_q    <= expected_d;
      marker_q      <= marker_d;
    end
  end

  assign Busy     = (state_q != S_IDLE);
  assign Pattern  = pattern_q;
  assign Expected = expected_q;
  assign Marker   = marker_q;

  always_comb begin
    DataOut = 32'd0;
    if (Read && hit) begin
      case (Address[1:0])
        2'b00:   DataOut = {Busy, 31'd0};
        2'b01:   DataOut = shape_q;
        2'b10:   DataOut = {16'd0, period_q};
        default: DataOut = {sent_q, burst_q};
      endcase
    end
  end

endmodule

// File: tb/tb_fine_time_pulse_gen.sv
// Self-checking bench for fine_time_pulse_gen: reset defaults, a table of
// directed pulse shapes, burst/continuous/abort/reset sequences, and random
// configurations compared cycle by cycle against a slice-level model.
module tb_fine_time_pulse_gen;

  localparam logic [5:0] CH = 6'd0;
  localparam logic [1:0] R_CTRL = 2'd0, R_SHAPE = 2'd1, R_PERIOD = 2'd2, R_BURST = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] DataIn;
  logic [7:0]  Address;
  logic        Read;
  logic        Write;
  logic [31:0] DataOut;
  logic [31:0] Pattern;
  logic [31:0] Expected;
  logic        Marker;
  logic        Busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #10 clk = ~clk;

  fine_time_pulse_gen #(.Ch(CH), .DefPeriod(16'd50)) dut (
    .clk(clk), .rst(rst), .DataIn(DataIn), .Address(Address), .Read(Read),
    .Write(Write), .DataOut(DataOut), .Pattern(Pattern), .Expected(Expected),
    .Marker(Marker), .Busy(Busy)
  );

  // ---------------- helpers / drivers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] reg_a, input logic [31:0] d);
    @(negedge clk);
    Address = {CH, reg_a};
    DataIn  = d;
    Write   = 1'b1;
    @(posedge clk);
    #1;
    Write   = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] reg_a, output logic [31:0] d);
    Address = {CH, reg_a};
    Read    = 1'b1;
    #1;
    d       = DataOut;
    Read    = 1'b0;
  endtask

  // Slice-level reference: what the line looks like k edges after the GO edge.
  function automatic void model(input int s, input int wraw, input int praw, input int n,
                                input int k, output logic [31:0] pat, output logic [31:0] lead,
                                output logic mk, output logic busy);
    int w, p, off, idx, ph;
    logic [31:0] first, spill;
    w = (wraw == 0) ? 1 : ((wraw > 32) ? 32 : wraw);
    p = (praw < 2) ? 2 : praw;
    first = '0;
    spill = '0;
    for (int b = 0; b < 64; b++)
      if (b >= s && b < s + w) begin
        if (b < 32) first[b] = 1'b1;
        else        spill[b - 32] = 1'b1;
      end
    busy = (n == 0) ? 1'b1 : (k < n * p);
    pat  = '0;
    lead = '0;
    mk   = 1'b0;
    if (k >= 1) begin
      off = k - 1;
      idx = off / p;
      ph  = off % p;
      if (n == 0 || idx < n) begin
        if (ph == 0) begin
          pat     = first;
          mk      = 1'b1;
          lead[s] = 1'b1;
        end else if (ph == 1) begin
          pat = spill;
        end
      end
    end
  endfunction

  typedef struct {
    int          start;
    int          width;
    int          period;
    logic [31:0] first;
    logic [31:0] spill;
    logic [31:0] lead;
    int          p_eff;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [31:0] rd;
    int          k;
    int          seen;

    vecs[0] = '{4,  4,  4, 32'h0000_00F0, 32'h0000_0000, 32'h0000_0010, 4};
    vecs[1] = '{30, 5,  3, 32'hC000_0000, 32'h0000_0007, 32'h4000_0000, 3};
    vecs[2] = '{0,  0,  0, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 2};
    vecs[3] = '{31, 40, 2, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 2};
    vecs[4] = '{0,  32, 5, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 5};
    vecs[5] = '{16, 16, 1, 32'hFFFF_0000, 32'h0000_0000, 32'h0001_0000, 2};
    vecs[6] = '{8,  63, 3, 32'hFFFF_FF00, 32'h0000_00FF, 32'h0000_0100, 3};

    rst = 1'b0; DataIn = '0; Address = '0; Read = 1'b0; Write = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();

    // ---------------- reset defaults ----------------
    check("rst_pattern", Pattern, 32'h0);
    check("rst_expected", Expected, 32'h0);
    check("rst_marker", {31'd0, Marker}, 32'h0);
    check("rst_busy", {31'd0, Busy}, 32'h0);
    bus_read(R_CTRL, rd);   check("rst_ctrl", rd, 32'h0000_0000);
    bus_read(R_SHAPE, rd);  check("rst_shape", rd, 32'h0000_0100);
    bus_read(R_PERIOD, rd); check("rst_period", rd, 32'h0000_0032);
    bus_read(R_BURST, rd);  check("rst_burst", rd, 32'h0000_0001);
    Address = 8'h10; Read = 1'b1; #1;
    check("addr_miss", DataOut, 32'h0);
    Read = 1'b0;

    // ---------------- table-driven single pulses ----------------
    for (int v = 0; v < 7; v++) begin
      bus_write(R_SHAPE, {18'd0, 6'(vecs[v].width), 3'd0, 5'(vecs[v].start)});
      bus_write(R_PERIOD, 32'(vecs[v].period));
      bus_write(R_BURST, 32'd1);
      bus_write(R_CTRL, 32'd1);
      check("vec_go_busy", {31'd0, Busy}, 32'h1);
      check("vec_go_pattern", Pattern, 32'h0);
      step();
      check("vec_first", Pattern, vecs[v].first);
      check("vec_lead", Expected, vecs[v].lead);
      check("vec_marker1", {31'd0, Marker}, 32'h1);
      step();
      check("vec_spill", Pattern, vecs[v].spill);
      check("vec_lead2", Expected, 32'h0);
      check("vec_marker2", {31'd0, Marker}, 32'h0);
      k = 2;
      while (Busy === 1'b1 && k < 200) begin
        step();
        k++;
      end
      check("vec_busy_drop", 32'(k), 32'(vecs[v].p_eff));
      bus_read(R_BURST, rd);
      check("vec_sent", rd, 32'h0001_0001);
    end

    // ---------------- burst of 4, GO while busy ignored ----------------
    bus_write(R_SHAPE, 32'h0000_0100);
    bus_write(R_PERIOD, 32'd3);
    bus_write(R_BURST, 32'd4);
    exp_q = {32'd1, 32'd4, 32'd7, 32'd10};
    bus_write(R_CTRL, 32'd1);
    for (int kk = 1; kk <= 14; kk++) begin
      if (kk == 6) begin
        Address = {CH, R_CTRL}; DataIn = 32'd1; Write = 1'b1;
      end
      step();
      Write = 1'b0;
      if (Marker === 1'b1) begin
        if (exp_q.size() == 0) check("burst_extra_marker", 32'(kk), 32'h0);
        else check("burst_marker_clk", 32'(kk), exp_q.pop_front());
      end
    end
    check("burst_markers_left", 32'(exp_q.size()), 32'h0);
    check("burst_busy_end", {31'd0, Busy}, 32'h0);
    bus_read(R_BURST, rd);
    check("burst_sent", rd, 32'h0004_0004);

    // ---------------- continuous, then ABORT+GO ----------------
    bus_write(R_PERIOD, 32'd2);
    bus_write(R_BURST, 32'd0);
    bus_write(R_CTRL, 32'd1);
    seen = 0;
    k = 0;
    while (seen < 5 && k < 40) begin
      step();
      k++;
      if (Marker === 1'b1) seen++;
    end
    check("cont_markers", 32'(seen), 32'd5);
    bus_write(R_CTRL, 32'd3);
    check("abort_busy", {31'd0, Busy}, 32'h0);
    check("abort_pattern", Pattern, 32'h0);
    check("abort_marker", {31'd0, Marker}, 32'h0);
    check("abort_expected", Expected, 32'h0);
    repeat (3) step();
    check("abort_stays_idle", {31'd0, Busy}, 32'h0);
    bus_read(R_BURST, rd);
    check("abort_sent", rd, 32'h0005_0000);

    // ---------------- randomized vs model ----------------
    for (int it = 0; it < 10; it++) begin
      int s, wr, pr, n;
      logic [31:0] m_pat, m_lead;
      logic        m_mk, m_busy;
      s  = int'($urandom_range(0, 31));
      wr = int'($urandom_range(0, 40));
      pr = int'($urandom_range(0, 6));
      n  = int'($urandom_range(1, 3));
      bus_write(R_SHAPE, {18'd0, 6'(wr), 3'd0, 5'(s)});
      bus_write(R_PERIOD, 32'(pr));
      bus_write(R_BURST, 32'(n));
      bus_write(R_CTRL, 32'd1);
      for (int kk = 0; kk <= n * ((pr < 2) ? 2 : pr) + 1; kk++) begin
        if (kk > 0) step();
        model(s, wr, pr, n, kk, m_pat, m_lead, m_mk, m_busy);
        check("rnd_pattern", Pattern, m_pat);
        check("rnd_expected", Expected, m_lead);
        check("rnd_marker", {31'd0, Marker}, {31'd0, m_mk});
        check("rnd_busy", {31'd0, Busy}, {31'd0, m_busy});
      end
      bus_read(R_BURST, rd);
      check("rnd_sent", rd, {16'(n), 16'(n)});
    end

    // ---------------- async reset mid-WAIT ----------------
    bus_write(R_SHAPE, 32'h0000_0405);
    bus_write(R_PERIOD, 32'd8);
    bus_write(R_BURST, 32'd3);
    bus_write(R_CTRL, 32'd1);
    repeat (3) step();
    check("wait_busy", {31'd0, Busy}, 32'h1);
    #5 rst = 1'b0;
    #1;
    check("rstw_busy", {31'd0, Busy}, 32'h0);
    check("rstw_pattern", Pattern, 32'h0);
    check("rstw_marker", {31'd0, Marker}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    step();
    bus_read(R_SHAPE, rd);
    check("rstw_shape", rd, 32'h0000_0100);
    bus_read(R_BURST, rd);
    check("rstw_burst", rd, 32'h0000_0001);

    // ---------------- async reset during a SPILL word ----------------
    bus_write(R_SHAPE, 32'h0000_051E);
    bus_write(R_CTRL, 32'd1);
    repeat (2) step();
    check("spill_word", Pattern, 32'h0000_0007);
    #5 rst = 1'b0;
    #1;
    check("rsts_pattern", Pattern, 32'h0);
    check("rsts_busy", {31'd0, Busy}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, want finish");
    $fatal(1);
  end

endmodule
